// File: rtl/ps2_rx_if.sv
// Byte handoff from the PS/2 receiver FIFO to the keyboard decoder.
// The master drives the head byte and valid; the slave acks to pop the head.
interface ps2_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;

    modport master (output rx_data, output rx_valid, input rx_ack);
    modport slave  (input rx_data, input rx_valid, output rx_ack);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync + deglitch pins, frame 11-bit packets, queue bytes in a FIFO.
// Latency: pin edge to filtered edge is 2+FILTER_LEN cycles; stop-bit sample to rx_valid is 1 cycle.
// Backpressure: none toward the device; a byte arriving at a full FIFO is dropped with an overflow pulse.
// Optional parity checking is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx #(
    parameter int FILTER_LEN     = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      ps2_clk_in,
    input  logic      ps2_dat_in,
    ps2_rx_if.master  rx,
    output logic      frame_err,
    output logic      parity_err,
    output logic      overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 is the clock pin, index 1 the data pin.
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] flt_cnt [2];
    logic          clk_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
            clk_d      <= 1'b1;
        end else begin
            sync1 <= {ps2_dat_in, ps2_clk_in};
            sync2 <= sync1;
            clk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i]    <= ~filt[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FW'(1);
                end
            end
        end
    end

    logic sample_evt, dat_s;
    assign sample_evt = clk_d & ~filt[0];
    assign dat_s      = filt[1];

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          push, ferr, perr, shift_en, par_en, clr_cnt;

    assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_bit, par_ok;
    assign par_ok = ^{shreg, par_bit};
`endif

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        ferr      = 1'b0;
        perr      = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        clr_cnt   = 1'b0;
        if (state != IDLE && !sample_evt && timeout) begin
            state_nxt = IDLE;
            ferr      = 1'b1;
        end else if (sample_evt) begin
            case (state)
                IDLE: begin
                    if (!dat_s) begin
                        state_nxt = DATA;
                        clr_cnt   = 1'b1;
                    end else begin
                        ferr = 1'b1;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!dat_s) begin
                        ferr = 1'b1;
                    end else begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        push = par_ok;
                        perr = ~par_ok;
`else
                        push = 1'b1;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg[bit_cnt] <= dat_s;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            // Saturating watchdog; only armed while a frame is in progress.
            if (state == IDLE || sample_evt) to_cnt <= '0;
            else if (!timeout)               to_cnt <= to_cnt + TW'(1);
        end
    end

    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rx.rx_ack & ~empty;
    assign wr_en = push & (~full | pop);

    assign rx.rx_valid = ~empty;
    assign rx.rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            frame_err <= ferr;
            overflow  <= push & full & ~pop;
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) par_bit <= dat_s;
            parity_err <= perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames on the raw pins and checks FIFO output and error pulses.
module tb_ps2_rx;
    localparam int FL    = 16;
    localparam int TO    = 1000;
    localparam int DEPTH = 4;
    localparam int H     = 40;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk_in = 1'b1;
    logic ps2_dat_in = 1'b1;
    logic frame_err, parity_err, overflow;

    ps2_rx_if bus();

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .rx         (bus),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int n_ferr = 0, n_perr = 0, n_ovf = 0;

    always @(posedge clock) begin
        if (frame_err  === 1'b1) n_ferr++;
        if (parity_err === 1'b1) n_perr++;
        if (overflow   === 1'b1) n_ovf++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Frame layout, LSB sent first: start(0), data[0..7], parity, stop.
    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop, input int n);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2_dat_in = f[i];
            wait_cyc(H);
            ps2_clk_in = 1'b0;
            wait_cyc(H);
            ps2_clk_in = 1'b1;
        end
        ps2_dat_in = 1'b1;
        wait_cyc(H);
    endtask

    task automatic ack_one();
        @(negedge clock);
        bus.rx_ack = 1'b1;
        @(negedge clock);
        bus.rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        tests++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_single();
        int f0, p0, o0;
        f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
        send_bits(8'h1C, 1'b0, 1'b1, 11);
        tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'h1C) begin fails++; $display("FAIL single_data got %h want 1c", bus.rx_data); end
        tests++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0 || n_ovf - o0 !== 0) begin
            fails++; $display("FAIL single_errs got f=%0d p=%0d o=%0d want 0", n_ferr - f0, n_perr - p0, n_ovf - o0);
        end
        ack_one();
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL single_ack_valid got %b want 0", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL single_ack_data got %h want 00", bus.rx_data); end
    endtask

    task automatic test_two();
        logic [7:0] exp [2];
        exp[0] = 8'hF0; exp[1] = 8'h1C;
        send_bits(8'hF0, 1'b1, 1'b1, 11);
        send_bits(8'h1C, 1'b0, 1'b1, 11);
        for (int i = 0; i < 2; i++) begin
            tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== exp[i]) begin
                fails++; $display("FAIL two_pop%0d got v=%b d=%h want v=1 d=%h", i, bus.rx_valid, bus.rx_data, exp[i]);
            end
            ack_one();
        end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL two_empty got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] dat [5];
        logic       par [5];
        int o0;
        dat = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        par = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        o0 = n_ovf;
        for (int i = 0; i < 5; i++) begin
            send_bits(dat[i], par[i], 1'b1, 11);
            if (i == 3) begin
                tests++; if (n_ovf - o0 !== 0) begin fails++; $display("FAIL ovf_early got %0d want 0", n_ovf - o0); end
            end
        end
        tests++; if (n_ovf - o0 !== 1) begin fails++; $display("FAIL ovf_pulse got %0d want 1", n_ovf - o0); end
        @(negedge clock);
        bus.rx_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== dat[i]) begin
                fails++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, bus.rx_valid, bus.rx_data, dat[i]);
            end
            @(negedge clock);
        end
        bus.rx_ack = 1'b0;
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_parity();
        int p0;
        p0 = n_perr;
        send_bits(8'h1C, 1'b1, 1'b1, 11);
`ifdef PS2_RX_PARITY_CHECK_EN
        tests++; if (n_perr - p0 !== 1) begin fails++; $display("FAIL parity_pulse got %0d want 1", n_perr - p0); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL parity_nopush got %b want 0", bus.rx_valid); end
`else
        tests++; if (n_perr - p0 !== 0) begin fails++; $display("FAIL parity_pulse got %0d want 0", n_perr - p0); end
        tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h1C) begin
            fails++; $display("FAIL parity_push got v=%b d=%h want v=1 d=1c", bus.rx_valid, bus.rx_data);
        end
        ack_one();
`endif
    endtask

    task automatic test_stop_err();
        int f0;
        f0 = n_ferr;
        send_bits(8'h1C, 1'b0, 1'b0, 11);
        tests++; if (n_ferr - f0 !== 1) begin fails++; $display("FAIL stop_ferr got %0d want 1", n_ferr - f0); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL stop_nopush got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = n_ferr;
        ps2_clk_in = 1'b0;
        wait_cyc(5);
        ps2_clk_in = 1'b1;
        wait_cyc(2 * H);
        tests++; if (n_ferr - f0 !== 0) begin fails++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - f0); end
        send_bits(8'h1C, 1'b0, 1'b1, 11);
        tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h1C || n_ferr - f0 !== 0) begin
            fails++; $display("FAIL glitch_after got v=%b d=%h f=%0d want v=1 d=1c f=0", bus.rx_valid, bus.rx_data, n_ferr - f0);
        end
        ack_one();
    endtask

    task automatic test_timeout();
        int f0;
        f0 = n_ferr;
        send_bits(8'h5A, 1'b1, 1'b1, 4);
        wait_cyc(TO + 200);
        tests++; if (n_ferr - f0 !== 1) begin fails++; $display("FAIL timeout_ferr got %0d want 1", n_ferr - f0); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL timeout_nopush got %b want 0", bus.rx_valid); end
        send_bits(8'h5A, 1'b1, 1'b1, 11);
        tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A || n_ferr - f0 !== 1) begin
            fails++; $display("FAIL timeout_next got v=%b d=%h f=%0d want v=1 d=5a f=1", bus.rx_valid, bus.rx_data, n_ferr - f0);
        end
        ack_one();
    endtask

    task automatic test_reset_mid();
        int f0;
        send_bits(8'h33, 1'b1, 1'b1, 11);
        send_bits(8'h5A, 1'b1, 1'b1, 5);
        #3 reset_n = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        tests++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin
            fails++; $display("FAIL rstmid_fifo got v=%b d=%h want v=0 d=00", bus.rx_valid, bus.rx_data);
        end
        f0 = n_ferr;
        send_bits(8'h1C, 1'b0, 1'b1, 11);
        tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h1C || n_ferr - f0 !== 0) begin
            fails++; $display("FAIL rstmid_next got v=%b d=%h f=%0d want v=1 d=1c f=0", bus.rx_valid, bus.rx_data, n_ferr - f0);
        end
        ack_one();
    endtask

    initial begin
        bus.rx_ack = 1'b0;
        wait_cyc(4);
        reset_n = 1'b1;
        wait_cyc(2);
        test_reset();
        test_single();
        test_two();
        test_overflow();
        test_parity();
        test_stop_err();
        test_glitch();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Bit-level PS/2 device-to-host receiver, upstream of the keyboard decoder. Synchronizes and deglitches the raw PS/2 clock/data pins and frames 11-bit packets (start, 8 data LSB-first, odd parity, stop). Pushes good scan-code bytes into a small FIFO, which the decoder drains with a valid/ack handshake. Reports framing, parity, timeout and overflow errors as single-cycle pulses.

## Interface
- FILTER_LEN, 16: consecutive identical samples needed before a filtered line changes level (≥2)
- TIMEOUT_CYCLES, 100000: max clock cycles between sample events inside a frame (2 ms at 50 MHz)
- FIFO_DEPTH, 4: byte FIFO entries, power of 2, ≥2
- clock  in  1  system clock; all state on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous
- ps2_dat_in  in  1  raw PS/2 data pin, asynchronous
- rx_data  out  8  FIFO head byte; 8'h00 when empty
- rx_valid  out  1  FIFO non-empty
- rx_ack  in  1  pop head when rx_valid=1; ignored when rx_valid=0
- frame_err  out  1  one-cycle pulse: bad start, bad stop or timeout
- parity_err  out  1  one-cycle pulse: parity mismatch (see Configuration)
- overflow  out  1  one-cycle pulse: good byte dropped, FIFO full

## Operation
- Each pin: 2-flop synchronizer, then filter. Run-length counter counts samples differing from the filtered level; filtered level toggles when count reaches FILTER_LEN; any sample equal to filtered level clears the count. Filtered levels reset to 1.
- Sample event: filtered clock 1→0. Filtered data captured on that cycle.
- FSM states IDLE, DATA, PARITY, STOP; 3-bit bit counter, 8-bit shift register.
- IDLE: event with dat=0 → DATA, counter=0; dat=1 → frame_err pulse, stay IDLE.
- DATA: shift dat into bit[counter] (LSB first); after 8th bit → PARITY.
- PARITY: store parity bit → STOP.
- STOP: dat=1 and parity OK → push byte, IDLE. dat=0 → frame_err, no push, IDLE. dat=1 and parity bad → parity_err, no push, IDLE.
- Parity OK: XOR of 8 data bits and parity bit = 1.
- Timeout: counter cleared on every sample event and in IDLE; outside IDLE reaching TIMEOUT_CYCLES → frame_err, discard partial byte, IDLE. Saturates; never wraps.
- FIFO: circular buffer, pointers one bit wider than log2(FIFO_DEPTH) for full/empty. Push into full FIFO: byte dropped, overflow pulse, contents unchanged. Push and pop in the same cycle when full: both occur, no overflow. Same cycle when empty: push only; popped head is the new byte next cycle.
- At most one error pulse per frame; error pulses never coincide with a push.

## Timing
- Pin edge → filtered edge: 2 + FILTER_LEN cycles for a clean edge.
- Stop-bit sample event on cycle N → FIFO written at edge ending N; rx_valid=1 and rx_data valid from cycle N+1.
- Error/overflow pulses: exactly one cycle, cycle N+1.
- rx_ack sampled with rx_valid=1 on cycle M → head advances, rx_data/rx_valid updated at M+1. Back-to-back acks pop one byte per cycle.
- Reset (async assert, sync release): rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overflow=0; FIFO empty, FSM IDLE, filters at 1, counters 0. Reset mid-frame discards partial byte and FIFO contents.

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: parity evaluated as above; bad-parity frames dropped with parity_err pulse.
- Not defined: parity bit captured but ignored; any frame with valid start/stop is pushed; parity_err tied 0.

## Test plan
- Frame 0x1C (parity bit 0, stop 1), bit period 80 µs → rx_valid=1, rx_data=0x1C, no error pulses; rx_ack → rx_valid=0, rx_data=0x00.
- Frames 0xF0 then 0x1C, no ack → FIFO holds 2; acks return 0xF0 then 0x1C in order.
- Five good frames 0x11..0x15, FIFO_DEPTH=4, no ack → overflow pulse on the 5th; drain returns 0x11..0x14.
- Frame 0x1C with parity bit 1 → macro defined: parity_err pulse, FIFO empty; undefined: 0x1C pushed, no pulse.
- Stop bit 0 → frame_err pulse, no push; 5-cycle low glitch on ps2_clk_in with FILTER_LEN=16 → no sample event, FSM unchanged.
- Clock only start + 3 data bits, then idle TIMEOUT_CYCLES → frame_err pulse, FSM IDLE; next full frame 0x5A received correctly.
